// File: rtl/recepcao_medida_pkg.sv
// Frame format shared by the trena transmit and receive sides.
package recepcao_medida_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NOVE = 8'h39;
  localparam logic [7:0] ASCII_HASH = 8'h23;

  // Codes double as the db_estado debug value.
  typedef enum logic [3:0] {
    StEsperaCentena = 4'd0,
    StEsperaDezena  = 4'd1,
    StEsperaUnidade = 4'd2,
    StEsperaHash    = 4'd3,
    StFinal         = 4'd4,
    StErro          = 4'd5,
    StDescarta      = 4'd6
  } estado_t;

  localparam logic [3:0] EST_INVALIDO = 4'hE;

  // Three BCD digits to binary; all products formed at 10 bits so 999 fits.
  function automatic logic [9:0] bcd_para_bin(input logic [3:0] c, input logic [3:0] d,
                                               input logic [3:0] u);
    return (10'(c) * 10'd100) + (10'(d) * 10'd10) + 10'(u);
  endfunction

endpackage

// File: rtl/recepcao_medida_contador_timeout.sv
// Modulo counter for the inter-byte timeout; o_fim flags the edge on which
// the count would reach MODULO-1.
module contador_timeout #(
  parameter int unsigned MODULO = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_fim
);

  localparam int unsigned W = (MODULO > 2) ? $clog2(MODULO) : 1;

  logic [W-1:0] r_cont;

  // Count while enabled; a clear always wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cont <= '0;
    end else if (i_clr) begin
      r_cont <= '0;
    end else if (i_en) begin
      if (r_cont == W'(MODULO - 1)) r_cont <= '0;
      else                          r_cont <= r_cont + W'(1);
    end
  end

  // Terminal edge: the increment about to happen lands on MODULO-1.
  always_comb begin
    o_fim = i_en && !i_clr && (r_cont == W'(MODULO - 2));
  end

endmodule

// File: rtl/recepcao_medida.sv
// Parses "DDD#" measurement frames from the UART receiver into BCD and binary.
module recepcao_medida
  import recepcao_medida_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 50_000_000,
  parameter logic [7:0]  TERMINADOR     = ASCII_HASH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  dado_recebido,
  input  logic        pronto_recepcao,
  output logic [11:0] medida_bcd,
  output logic [9:0]  medida_bin,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  estado_t     r_estado, w_estado_d;
  logic        r_term_visto, w_term_visto_d;
  logic [3:0]  r_centena, w_centena_d;
  logic [3:0]  r_dezena, w_dezena_d;
  logic [3:0]  r_unidade, w_unidade_d;
  logic [11:0] r_bcd, w_bcd_d;
  logic [9:0]  r_bin, w_bin_d;

  logic       w_digito_ok;
  logic       w_term_ok;
  logic [3:0] w_valor;
  logic       w_conta;
  logic       w_clr;
  logic       w_fim;

  // Byte classification.
  always_comb begin
    w_digito_ok = (dado_recebido >= ASCII_ZERO) && (dado_recebido <= ASCII_NOVE);
    w_term_ok   = (dado_recebido == TERMINADOR);
    w_valor     = 4'(dado_recebido - ASCII_ZERO);
  end

  // Timeout runs only while a frame is partially received or being discarded.
  always_comb begin
    w_conta = (r_estado == StEsperaDezena) || (r_estado == StEsperaUnidade) ||
              (r_estado == StEsperaHash)   || (r_estado == StDescarta);
    w_clr   = pronto_recepcao || !w_conta;
  end

  contador_timeout #(
    .MODULO (TIMEOUT_CICLOS)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (w_conta),
    .o_fim (w_fim)
  );

  // State and holding registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado     <= StEsperaCentena;
      r_term_visto <= 1'b0;
      r_centena    <= '0;
      r_dezena     <= '0;
      r_unidade    <= '0;
      r_bcd        <= '0;
      r_bin        <= '0;
    end else begin
      r_estado     <= w_estado_d;
      r_term_visto <= w_term_visto_d;
      r_centena    <= w_centena_d;
      r_dezena     <= w_dezena_d;
      r_unidade    <= w_unidade_d;
      r_bcd        <= w_bcd_d;
      r_bin        <= w_bin_d;
    end
  end

  // Next-state logic; a byte strobe takes priority over timeout expiry.
  always_comb begin
    w_estado_d     = r_estado;
    w_term_visto_d = r_term_visto;
    w_centena_d    = r_centena;
    w_dezena_d     = r_dezena;
    w_unidade_d    = r_unidade;
    w_bcd_d        = r_bcd;
    w_bin_d        = r_bin;
    unique case (r_estado)
      StEsperaCentena: begin
        if (pronto_recepcao) begin
          if (w_digito_ok) begin
            w_centena_d = w_valor;
            w_estado_d  = StEsperaDezena;
          end else begin
            w_estado_d     = StErro;
            w_term_visto_d = w_term_ok;
          end
        end
      end
      StEsperaDezena: begin
        if (pronto_recepcao) begin
          if (w_digito_ok) begin
            w_dezena_d = w_valor;
            w_estado_d = StEsperaUnidade;
          end else begin
            w_estado_d     = StErro;
            w_term_visto_d = w_term_ok;
          end
        end else if (w_fim) begin
          w_estado_d     = StErro;
          w_term_visto_d = 1'b1;
        end
      end
      StEsperaUnidade: begin
        if (pronto_recepcao) begin
          if (w_digito_ok) begin
            w_unidade_d = w_valor;
            w_estado_d  = StEsperaHash;
          end else begin
            w_estado_d     = StErro;
            w_term_visto_d = w_term_ok;
          end
        end else if (w_fim) begin
          w_estado_d     = StErro;
          w_term_visto_d = 1'b1;
        end
      end
      StEsperaHash: begin
        if (pronto_recepcao) begin
          if (w_term_ok) begin
            w_estado_d = StFinal;
            w_bcd_d    = {r_centena, r_dezena, r_unidade};
            w_bin_d    = bcd_para_bin(r_centena, r_dezena, r_unidade);
          end else begin
            w_estado_d     = StErro;
            w_term_visto_d = 1'b0;
          end
        end else if (w_fim) begin
          w_estado_d     = StErro;
          w_term_visto_d = 1'b1;
        end
      end
      StFinal: begin
        w_estado_d = StEsperaCentena;
      end
      StErro: begin
        // Terminator already consumed: resync directly, else drain to '#'.
        w_estado_d = r_term_visto ? StEsperaCentena : StDescarta;
      end
      StDescarta: begin
        if (pronto_recepcao) begin
          if (w_term_ok) w_estado_d = StEsperaCentena;
        end else if (w_fim) begin
          w_estado_d = StEsperaCentena;
        end
      end
      default: begin
        w_estado_d = StEsperaCentena;
      end
    endcase
  end

  // Moore outputs and debug state code.
  always_comb begin
    medida_bcd = r_bcd;
    medida_bin = r_bin;
    pronto     = (r_estado == StFinal);
    erro       = (r_estado == StErro);
    unique case (r_estado)
      StEsperaCentena, StEsperaDezena, StEsperaUnidade, StEsperaHash,
      StFinal, StErro, StDescarta: db_estado = r_estado;
      default:                     db_estado = EST_INVALIDO;
    endcase
  end

endmodule

// File: tb/tb_recepcao_medida.sv
// Scoreboard bench for recepcao_medida: stimulus pushes expected pulses,
// a negedge monitor pops and compares them.
module tb_recepcao_medida;

  localparam int unsigned TO = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  dado_recebido = 8'h00;
  logic        pronto_recepcao = 1'b0;
  logic [11:0] medida_bcd;
  logic [9:0]  medida_bin;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  recepcao_medida #(
    .TIMEOUT_CICLOS (TO),
    .TERMINADOR     (8'h23)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .dado_recebido   (dado_recebido),
    .pronto_recepcao (pronto_recepcao),
    .medida_bcd      (medida_bcd),
    .medida_bin      (medida_bin),
    .pronto          (pronto),
    .erro            (erro),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_erro;
    logic [11:0] bcd;
    logic [9:0]  bin;
    int          cyc;
  } esperado_t;

  esperado_t fila[$];
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int last_cyc = 0;

  always @(posedge clock) ncyc <= ncyc + 1;

  // Monitor: every pronto/erro pulse must match the head of the queue.
  always @(negedge clock) begin
    if (reset) begin
      if (pronto && erro) begin
        checks++; errors++;
        $display("FAIL exclusive: pronto=1 erro=1 required not both");
      end
      if (pronto || erro) begin
        checks++;
        if (fila.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got pronto=%0b erro=%0b at cyc %0d, required none",
                   pronto, erro, ncyc);
        end else begin
          esperado_t e;
          e = fila.pop_front();
          if ((erro != e.is_erro) || (ncyc != e.cyc)) begin
            errors++;
            $display("FAIL pulse_kind: got erro=%0b cyc=%0d, required erro=%0b cyc=%0d",
                     erro, ncyc, e.is_erro, e.cyc);
          end
          checks++;
          if ((medida_bcd != e.bcd) || (medida_bin != e.bin)) begin
            errors++;
            $display("FAIL medida: got bcd=%h bin=%0d, required bcd=%h bin=%0d",
                     medida_bcd, medida_bin, e.bcd, e.bin);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    dado_recebido = b;
    pronto_recepcao = 1'b1;
    @(posedge clock); #1;
    pronto_recepcao = 1'b0;
    last_cyc = ncyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Sends "abc#" with 8-cycle gaps and expects pronto with the given value.
  task automatic frame_ok(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [11:0] bcd, input logic [9:0] bin);
    esperado_t e;
    send_byte(a); idle(8);
    send_byte(b); idle(8);
    send_byte(c); idle(8);
    send_byte(8'h23);
    e.is_erro = 1'b0; e.bcd = bcd; e.bin = bin; e.cyc = last_cyc;
    fila.push_back(e);
    idle(8);
  endtask

  task automatic push_erro(input logic [11:0] bcd, input logic [9:0] bin, input int cyc);
    esperado_t e;
    e.is_erro = 1'b1; e.bcd = bcd; e.bin = bin; e.cyc = cyc;
    fila.push_back(e);
  endtask

  task automatic check_estado(input string nome, input logic [3:0] req);
    checks++;
    if (db_estado != req) begin
      errors++;
      $display("FAIL %s: db_estado got %h required %h", nome, db_estado, req);
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (medida_bcd != 12'h000 || medida_bin != 10'd0 || pronto || erro) begin
      errors++;
      $display("FAIL reset_outputs: bcd=%h bin=%0d pronto=%0b erro=%0b required all 0",
               medida_bcd, medida_bin, pronto, erro);
    end
    check_estado("reset_state", 4'h0);
    @(negedge clock);
    reset = 1'b1;
    idle(2);

    // Basic frame.
    frame_ok("1", "2", "3", 12'h123, 10'd123);
    check_estado("after_123", 4'h0);

    // Range extremes.
    frame_ok("0", "0", "0", 12'h000, 10'd0);
    frame_ok("9", "9", "9", 12'h999, 10'd999);

    // Invalid digit: erro, then discard until '#'.
    send_byte("4"); idle(8);
    send_byte("A");
    push_erro(12'h999, 10'd999, last_cyc);
    idle(3);
    check_estado("descarta", 4'h6);
    idle(5);
    send_byte("5"); idle(8);
    send_byte("6"); idle(8);
    check_estado("descarta_hold", 4'h6);
    send_byte(8'h23); idle(3);
    check_estado("descarta_exit", 4'h0);
    checks++;
    if (medida_bin != 10'd999) begin
      errors++;
      $display("FAIL medida_hold: got %0d required 999", medida_bin);
    end
    idle(5);
    frame_ok("0", "4", "2", 12'h042, 10'd42);

    // Early terminator: erro, then straight back to espera_centena.
    send_byte("7"); idle(8);
    send_byte(8'h23);
    push_erro(12'h042, 10'd42, last_cyc);
    idle(3);
    check_estado("term_early", 4'h0);
    idle(5);
    frame_ok("3", "1", "0", 12'h310, 10'd310);

    // Inter-byte timeout.
    send_byte("5"); idle(8);
    send_byte("6");
    push_erro(12'h310, 10'd310, last_cyc + int'(TO) - 1);
    idle(25);
    check_estado("timeout_state", 4'h0);
    frame_ok("1", "1", "1", 12'h111, 10'd111);

    // Asynchronous reset mid-frame.
    send_byte("8"); idle(8);
    send_byte("8");
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    checks++;
    if (medida_bcd != 12'h000 || medida_bin != 10'd0 || pronto || erro) begin
      errors++;
      $display("FAIL async_reset: bcd=%h bin=%0d pronto=%0b erro=%0b required all 0",
               medida_bcd, medida_bin, pronto, erro);
    end
    check_estado("async_reset_state", 4'h0);
    idle(3);
    @(negedge clock);
    reset = 1'b1;
    idle(2);
    frame_ok("0", "0", "1", 12'h001, 10'd1);

    // Every expected pulse must have been seen.
    idle(10);
    checks++;
    if (fila.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses: got %0d outstanding required 0", fila.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/recepcao_medida.md
Name: recepcao_medida

Overview:
- Receive-side parser for the measurement frame the trena sends over serial: three ASCII digits (hundreds, tens, units) followed by '#'.
- Sits after a UART receiver. Consumes one byte per receiver strobe and validates the frame.
- Outputs the distance as 3-digit BCD and as binary, with a one-cycle pronto pulse or a one-cycle erro pulse.
- Inter-byte timeout discards partial frames.

Parameters:
- TIMEOUT_CICLOS, 50_000_000, maximum clock cycles allowed between consecutive bytes of one frame (1 s at 50 MHz).
- TERMINADOR, 8'h23, ASCII frame terminator ('#').

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- dado_recebido  in  8  byte from the UART receiver; valid only while pronto_recepcao=1.
- pronto_recepcao  in  1  one-cycle strobe, byte available.
- medida_bcd  out  12  {centena, dezena, unidade} BCD of the last valid frame.
- medida_bin  out  10  centena*100 + dezena*10 + unidade, range 0..999.
- pronto  out  1  one-cycle pulse, new valid measurement.
- erro  out  1  one-cycle pulse, malformed or timed-out frame.
- db_estado  out  4  current state code.

Behaviour:
- Reset (reset=0, async): state espera_centena; medida_bcd=0, medida_bin=0, pronto=0, erro=0; timeout counter=0; digit holding registers=0; flag term_visto=0.
- Digit valid: 8'h30..8'h39, value = byte - 8'h30. Terminator valid: byte == TERMINADOR.
- States and db_estado codes:
  - espera_centena 0, espera_dezena 1, espera_unidade 2, espera_hash 3, final 4, erro 5, descarta 6.
  - Any other code goes to espera_centena; db_estado reports 4'hE for it.
- Transitions, evaluated only on edges with pronto_recepcao=1 unless noted:
  - espera_centena / espera_dezena / espera_unidade: valid digit -> store it, advance to the next state.
  - Same states, invalid byte -> erro; term_visto <= (byte == TERMINADOR).
  - espera_hash: TERMINADOR -> final. Any other byte -> erro with term_visto=0.
  - final, one cycle: pronto=1 -> espera_centena.
  - erro, one cycle: erro=1 -> espera_centena if term_visto=1, else descarta.
  - descarta: ignore bytes until TERMINADOR is received -> espera_centena.
- Output update: medida_bcd and medida_bin are registered from the held digits on the edge entering final, so they are valid the same cycle pronto=1. They hold until the next valid frame and are never changed by erro.
- Latency: '#' strobe sampled at edge N -> pronto=1 and the new medida visible during cycle N..N+1.
- pronto and erro are Moore outputs decoded from the state and are never high together.
- Timeout counter:
  - Increments each cycle in espera_dezena, espera_unidade, espera_hash and descarta.
  - Clears on any pronto_recepcao=1 and in every other state.
  - Reaching TIMEOUT_CICLOS-1 in a digit/hash state -> erro with term_visto=1, so the next state is espera_centena.
  - Reaching it in descarta -> espera_centena with no erro pulse.
- Simultaneous byte strobe and timeout expiry on the same edge: the byte wins; the counter clears.
- A strobe arriving while in final or erro is dropped. The receiver guarantees at least 2 cycles between strobes.
- espera_centena never times out; the line may idle indefinitely.
- reset asserted mid-frame aborts it immediately. No pulse is produced and medida returns to 0.
- Arithmetic: medida_bin is computed as centena*7'd100 + dezena*4'd10 + unidade, zero-extended to 10 bits, with no overflow possible.

Decomposition:
- Shared package holds:
  - State codes (4-bit).
  - ASCII_ZERO=8'h30, ASCII_NOVE=8'h39, ASCII_HASH=8'h23.
  - Shared with the transmit side so both ends agree on frame format.
- One sub-module: contador_timeout (parameterised modulo counter with clear and fim output). Instantiated once.
- The FSM, digit registers and BCD-to-binary logic stay in recepcao_medida.

Test Plan:
- Bytes "1","2","3","#" with 10-cycle gaps -> single pronto pulse; medida_bcd=12'h123, medida_bin=123; erro never high.
- Frame "0","0","0","#" then "9","9","9","#" -> first pronto with medida_bin=0, second with medida_bin=999 and medida_bcd=12'h999.
- Sequence:
  - Bytes "4","A","5","6","#" -> erro pulse after "A"; state descarta; "5","6" ignored; "#" returns to espera_centena; no pronto; medida unchanged.
  - Then "0","4","2","#" -> pronto with medida_bin=42.
- Bytes "7","#" -> erro pulse on "#", next state espera_centena directly. Following "3","1","0","#" -> pronto with medida_bin=310.
- With TIMEOUT_CICLOS=20, send "5","6" then idle 25 cycles -> erro pulse exactly 19 cycles after the "6" strobe, state espera_centena. "1","1","1","#" -> medida_bin=111.
- Assert reset=0 after "8","8" -> all outputs 0 asynchronously, db_estado=0. After release, "0","0","1","#" -> medida_bin=1.
